// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered multi-channel output mux.
package mux_pkg;

  // Channel selection policies
  localparam int MODE_SEL  = 0;  // explicit select input
  localparam int MODE_RR   = 1;  // round-robin
  localparam int MODE_PRIO = 2;  // fixed priority, lowest index wins

  // Width of a channel index; never below one bit so N = 1 still has a port
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: first requester above ptr, wrapping at N.
// With ptr tied to N-1 the search starts at 0, giving fixed priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx
);

  logic found;
  int   idx;

  // Walk the N candidates starting one past ptr and keep the first hit
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_arb_rr.sv
// N-to-1 arbitrated mux with a single output register stage.
// The register drains and refills in the same cycle, so it sustains one
// word per cycle while out_ready is held high.
module mux_arb_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = MODE_SEL,
  localparam int SW    = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SW-1:0]      sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_chan
);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    arb_ptr;
  logic [N-1:0]     arb_oh;
  logic [SW-1:0]    arb_idx;
  logic [N-1:0]     sel_oh;
  logic [N-1:0]     grant_oh;
  logic [SW-1:0]    grant;
  logic [WIDTH-1:0] grant_data;
  logic             can_load;
  logic             xfer;

  // Priority mode reuses the rotating search with the start fixed at channel 0
  assign arb_ptr = (MODE == MODE_RR) ? ptr : SW'(N - 1);

  rr_arbiter #(.N(N), .IW(SW)) u_arb (
    .req       (in_valid),
    .ptr       (arb_ptr),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  // Decode the explicit select; an out-of-range sel matches no channel
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i) sel_oh[i] = in_valid[i];
    end
  end

  // Pick the grant source for this mode (one-hot is empty when nothing is granted)
  always_comb begin
    if (MODE == MODE_SEL) begin
      grant_oh = sel_oh;
      grant    = sel;
    end else begin
      grant_oh = arb_oh;
      grant    = arb_idx;
    end
  end

  // Route the granted channel's word to the register input
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_oh[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // The register may accept when empty or when its word leaves this cycle
  assign can_load = !out_valid || out_ready;
  assign in_ready = (rst_n && can_load) ? grant_oh : '0;
  assign xfer     = |in_ready;

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SW'(N - 1);
    end else if (xfer) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant;
      if (MODE == MODE_RR) ptr <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_rr.sv
// Directed bench for mux_arb_rr: explicit-select, round-robin, priority and
// single-channel instances. Stimulus pushes expected words into per-instance
// queues; monitors pop and compare whenever a word leaves an output register.
module tb_mux_arb_rr;
  import mux_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  chan;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // MODE 0, N = 4
  logic [3:0]   s_v, s_r;
  logic [127:0] s_d;
  logic [1:0]   s_sel, s_oc;
  logic         s_ov, s_ordy;
  logic [31:0]  s_od;
  // MODE 0, N = 5 (select can go out of range)
  logic [4:0]   f_v, f_r;
  logic [159:0] f_d;
  logic [2:0]   f_sel, f_oc;
  logic         f_ov, f_ordy;
  logic [31:0]  f_od;
  // MODE 1, N = 4
  logic [3:0]   r_v, r_r;
  logic [127:0] r_d;
  logic [1:0]   r_sel, r_oc;
  logic         r_ov, r_ordy;
  logic [31:0]  r_od;
  // MODE 2, N = 4
  logic [3:0]   p_v, p_r;
  logic [127:0] p_d;
  logic [1:0]   p_sel, p_oc;
  logic         p_ov, p_ordy;
  logic [31:0]  p_od;
  // MODE 1, N = 1
  logic [0:0]   o_v, o_r;
  logic [31:0]  o_d;
  logic [0:0]   o_sel, o_oc;
  logic         o_ov, o_ordy;
  logic [31:0]  o_od;

  mux_arb_rr #(.WIDTH(W), .N(4), .MODE(MODE_SEL)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_valid(s_v), .in_ready(s_r), .in_data(s_d), .sel(s_sel),
    .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_od), .out_chan(s_oc));
  mux_arb_rr #(.WIDTH(W), .N(5), .MODE(MODE_SEL)) u_sel5 (
    .clk(clk), .rst_n(rst_n), .in_valid(f_v), .in_ready(f_r), .in_data(f_d), .sel(f_sel),
    .out_valid(f_ov), .out_ready(f_ordy), .out_data(f_od), .out_chan(f_oc));
  mux_arb_rr #(.WIDTH(W), .N(4), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(r_v), .in_ready(r_r), .in_data(r_d), .sel(r_sel),
    .out_valid(r_ov), .out_ready(r_ordy), .out_data(r_od), .out_chan(r_oc));
  mux_arb_rr #(.WIDTH(W), .N(4), .MODE(MODE_PRIO)) u_prio (
    .clk(clk), .rst_n(rst_n), .in_valid(p_v), .in_ready(p_r), .in_data(p_d), .sel(p_sel),
    .out_valid(p_ov), .out_ready(p_ordy), .out_data(p_od), .out_chan(p_oc));
  mux_arb_rr #(.WIDTH(W), .N(1), .MODE(MODE_RR)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(o_v), .in_ready(o_r), .in_data(o_d), .sel(o_sel),
    .out_valid(o_ov), .out_ready(o_ordy), .out_data(o_od), .out_chan(o_oc));

  exp_t q_s[$], q_r[$], q_p[$], q_o[$];
  exp_t e_s, e_r, e_p, e_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Move inputs just after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a word is consumed when out_valid and out_ready are both high
  always @(negedge clk) begin
    if (rst_n && s_ov && s_ordy) begin
      check("sel_word_expected", 64'(q_s.size() > 0), 64'd1);
      if (q_s.size() > 0) begin
        e_s = q_s.pop_front();
        check("sel_data", 64'(s_od), 64'(e_s.data));
        check("sel_chan", 64'(s_oc), 64'(e_s.chan));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && r_ov && r_ordy) begin
      check("rr_word_expected", 64'(q_r.size() > 0), 64'd1);
      if (q_r.size() > 0) begin
        e_r = q_r.pop_front();
        check("rr_data", 64'(r_od), 64'(e_r.data));
        check("rr_chan", 64'(r_oc), 64'(e_r.chan));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && p_ov && p_ordy) begin
      check("prio_word_expected", 64'(q_p.size() > 0), 64'd1);
      if (q_p.size() > 0) begin
        e_p = q_p.pop_front();
        check("prio_data", 64'(p_od), 64'(e_p.data));
        check("prio_chan", 64'(p_oc), 64'(e_p.chan));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && o_ov && o_ordy) begin
      check("one_word_expected", 64'(o_ov && q_o.size() > 0), 64'd1);
      if (q_o.size() > 0) begin
        e_o = q_o.pop_front();
        check("one_data", 64'(o_od), 64'(e_o.data));
        check("one_chan", 64'(o_oc), 64'(e_o.chan));
      end
    end
  end

  initial begin
    logic [3:0] exp_rdy;

    s_v = 4'hF; s_d = '0; s_sel = '0; s_ordy = 1'b1;
    f_v = '0;   f_d = '0; f_sel = '0; f_ordy = 1'b1;
    r_v = 4'hF; r_d = '0; r_sel = '0; r_ordy = 1'b1;
    p_v = 4'hF; p_d = '0; p_sel = '0; p_ordy = 1'b1;
    o_v = 1'b1; o_d = '0; o_sel = '0; o_ordy = 1'b1;
    for (int i = 0; i < 4; i++) r_d[i*W +: W] = 32'h1000_0000 + 32'(i);

    // Reset state, with requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(r_ov), 64'd0);
    check("rst_out_data",  64'(r_od), 64'd0);
    check("rst_out_chan",  64'(r_oc), 64'd0);
    check("rst_rr_ready",  64'(r_r),  64'd0);
    check("rst_sel_ready", 64'(s_r),  64'd0);
    check("rst_prio_ready", 64'(p_r), 64'd0);
    check("rst_one_ready", 64'(o_r),  64'd0);
    #1;
    s_v = '0; r_v = '0; p_v = '0; o_v = '0;
    step();
    rst_n = 1'b1;

    // MODE 0: sel = 2 forwards channel 2 with one cycle latency
    s_sel = 2'd2;
    s_d[2*W +: W] = 32'hDEAD_BEEF;
    s_v = 4'b0100;
    q_s.push_back('{32'hDEAD_BEEF, 4'd2});
    @(negedge clk);
    check("sel_ready_ch2", 64'(s_r), 64'b0100);
    step();
    s_v = '0;
    @(negedge clk);
    check("sel_valid_next", 64'(s_ov), 64'd1);
    step();

    // MODE 0: selected channel not requesting -> nothing moves
    s_sel = 2'd1;
    s_v = 4'b1101;
    @(negedge clk);
    check("sel_idle_ready", 64'(s_r), 64'd0);
    step();
    @(negedge clk);
    check("sel_idle_valid", 64'(s_ov), 64'd0);
    step();
    s_v = '0;

    // MODE 0: sel beyond the last channel never grants
    f_v = 5'h1F;
    f_sel = 3'd5;
    @(negedge clk);
    check("sel5_ready", 64'(f_r), 64'd0);
    step();
    f_sel = 3'd7;
    @(negedge clk);
    check("sel7_ready", 64'(f_r), 64'd0);
    check("sel5_valid", 64'(f_ov), 64'd0);
    step();
    f_v = '0;

    // MODE 1: all channels requesting rotate 0,1,2,3,0,1,2,3 at full rate
    r_v = 4'hF;
    for (int k = 0; k < 8; k++) begin
      q_r.push_back('{32'h1000_0000 + 32'(k % 4), 4'(k % 4)});
      exp_rdy = 4'(1 << (k % 4));
      @(negedge clk);
      check("rr_rotate_ready", 64'(r_r), 64'(exp_rdy));
      if (k > 0) check("rr_throughput", 64'(r_ov), 64'd1);
      step();
    end
    r_v = '0;
    @(negedge clk);
    check("rr_last_valid", 64'(r_ov), 64'd1);
    step();

    // MODE 1: after ch3, channels 0 and 1 requesting -> wrap to 0 then 1
    r_v = 4'b0011;
    q_r.push_back('{32'h1000_0000, 4'd0});
    @(negedge clk);
    check("rr_wrap_ch0", 64'(r_r), 64'b0001);
    step();
    q_r.push_back('{32'h1000_0001, 4'd1});
    @(negedge clk);
    check("rr_wrap_ch1", 64'(r_r), 64'b0010);
    step();
    r_v = '0;
    @(negedge clk);
    step();

    // MODE 2: lowest requester wins, then a stall holds the word
    p_d[1*W +: W] = 32'hAAAA_0001;
    p_d[3*W +: W] = 32'hAAAA_0003;
    p_ordy = 1'b0;
    p_v = 4'b1010;
    q_p.push_back('{32'hAAAA_0001, 4'd1});
    @(negedge clk);
    check("prio_ready_ch1", 64'(p_r), 64'b0010);
    step();
    p_d[1*W +: W] = 32'hBBBB_0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("prio_stall_ready", 64'(p_r), 64'd0);
      check("prio_stall_data", 64'(p_od), 64'hAAAA_0001);
      check("prio_stall_chan", 64'(p_oc), 64'd1);
      check("prio_stall_valid", 64'(p_ov), 64'd1);
      step();
    end
    p_ordy = 1'b1;
    q_p.push_back('{32'hBBBB_0001, 4'd1});
    @(negedge clk);
    check("prio_refill_ready", 64'(p_r), 64'b0010);
    step();
    p_v = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    check("prio_drained", 64'(p_ov), 64'd0);
    step();

    // Reset pulse while a word is stalled discards it asynchronously
    r_ordy = 1'b0;
    r_d[2*W +: W] = 32'h5555_0002;
    r_v = 4'b0100;
    @(negedge clk);
    check("rr_pre_reset_ready", 64'(r_r), 64'b0100);
    step();
    r_v = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(r_ov), 64'd0);
    check("async_rst_data",  64'(r_od), 64'd0);
    check("async_rst_chan",  64'(r_oc), 64'd0);
    step();
    rst_n = 1'b1;
    r_ordy = 1'b1;
    r_v = 4'hF;
    q_r.push_back('{32'h1000_0000, 4'd0});
    @(negedge clk);
    check("rr_post_reset_ch0", 64'(r_r), 64'b0001);
    step();
    r_v = '0;
    @(negedge clk);
    step();

    // N = 1: a plain one-entry pipeline stage at full rate
    o_d = 32'h1234_5678;
    o_v = 1'b1;
    q_o.push_back('{32'h1234_5678, 4'd0});
    @(negedge clk);
    check("one_ready_a", 64'(o_r), 64'd1);
    step();
    o_d = 32'h8765_4321;
    q_o.push_back('{32'h8765_4321, 4'd0});
    @(negedge clk);
    check("one_ready_b", 64'(o_r), 64'd1);
    step();
    o_v = '0;
    @(negedge clk);
    step();

    // Every expected word must have been observed
    repeat (3) step();
    check("sel_queue_empty",  64'(q_s.size()), 64'd0);
    check("rr_queue_empty",   64'(q_r.size()), 64'd0);
    check("prio_queue_empty", 64'(q_p.size()), 64'd0);
    check("one_queue_empty",  64'(q_o.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
